ci_master: RTL and testbench

//   CPU-side initiator for the custom-instruction (CI) bus. Drives the lines a CI

---
 rtl/ci_master.sv | 172 +++++++++++++++++
 tb/tb_ci_master.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ci_master.sv
// ci_master: CPU-side initiator for the custom-instruction (CI) bus.
//
// Takes one instruction at a time from a command port, drives it onto the CI
// bus (start strobe, id, operands, stall), waits for the responder's done and
// returns result, latency and timeout status on a response port.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both 1. cmdValid/cmd* must hold until accepted; rspValid and rsp* hold
// stable until rspReady is seen high. cmdReady never depends on rspReady.
//
// Ports:
//   clock, reset            clock, asynchronous active-low reset
//   cmdValid/cmdReady       command handshake; cmdCiN, cmdValueA, cmdValueB payload
//   ciStart                 one-cycle start strobe per command
//   ciN, ciValueA, ciValueB held instruction, 0 while idle
//   ciStall                 high while an instruction is in flight
//   ciDone, ciResult        responder completion and its result (same cycle)
//   rspValid/rspReady       response handshake; rspResult, rspTimeout, rspCycles payload
//   dbgState                current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
module ci_master #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int LAT_WIDTH      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmdValid,
    output logic                 cmdReady,
    input  logic [7:0]           cmdCiN,
    input  logic [31:0]          cmdValueA,
    input  logic [31:0]          cmdValueB,
    output logic                 ciStart,
    output logic [7:0]           ciN,
    output logic [31:0]          ciValueA,
    output logic [31:0]          ciValueB,
    output logic                 ciStall,
    input  logic                 ciDone,
    input  logic [31:0]          ciResult,
    output logic                 rspValid,
    input  logic                 rspReady,
    output logic [31:0]          rspResult,
    output logic                 rspTimeout,
    output logic [LAT_WIDTH-1:0] rspCycles,
    output logic [1:0]           dbgState
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [TW-1:0]        timer;
    logic [LAT_WIDTH-1:0] lat;
    logic [LAT_WIDTH-1:0] lat_now;
    logic                 capture;
    logic                 cap_timeout;
    logic                 timer_last;

    assign timer_last = (timer == TW'(TIMEOUT_CYCLES - 1));

    // Latency including the current cycle; ISSUE counts as 1, saturating.
    always_comb begin
        lat_now = lat;
        if (state == S_ISSUE) begin
            lat_now = LAT_WIDTH'(1);
        end else if (!(&lat)) begin
            lat_now = lat + LAT_WIDTH'(1);
        end
    end

    // Next state. ciDone is only looked at in ISSUE/WAIT, and beats the
    // timeout when both happen in the same cycle.
    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        cap_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmdValid) state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (ciDone) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ciDone) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end else if (timer_last) begin
                    capture     = 1'b1;
                    cap_timeout = 1'b1;
                    state_next  = S_RESP;
                end
            end
            S_RESP: begin
                if (rspReady) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // All strobes decode straight from the state register, which resets
    // asynchronously, so they drop as soon as reset is asserted.
    // cmdReady is additionally gated by reset so it stays 0 while in reset.
    assign cmdReady = reset && (state == S_IDLE);
    assign ciStart  = (state == S_ISSUE);
    assign ciStall  = (state == S_ISSUE) || (state == S_WAIT);
    assign rspValid = (state == S_RESP);
    assign dbgState = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            timer      <= '0;
            lat        <= '0;
            ciN        <= '0;
            ciValueA   <= '0;
            ciValueB   <= '0;
            rspResult  <= '0;
            rspTimeout <= 1'b0;
            rspCycles  <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (cmdValid) begin
                        ciN      <= cmdCiN;
                        ciValueA <= cmdValueA;
                        ciValueB <= cmdValueB;
                        lat      <= '0;
                    end
                end
                S_ISSUE: begin
                    lat   <= lat_now;
                    timer <= '0;
                end
                S_WAIT: begin
                    lat   <= lat_now;
                    timer <= timer + TW'(1);
                end
                S_RESP: begin
                    // Bus and response registers return to 0 for IDLE.
                    if (rspReady) begin
                        ciN        <= '0;
                        ciValueA   <= '0;
                        ciValueB   <= '0;
                        rspResult  <= '0;
                        rspTimeout <= 1'b0;
                        rspCycles  <= '0;
                    end
                end
                default: ;
            endcase
            // ciResult is sampled only here; a timeout captures 0.
            if (capture) begin
                rspResult  <= cap_timeout ? 32'd0 : ciResult;
                rspTimeout <= cap_timeout;
                rspCycles  <= lat_now;
            end
        end
    end

endmodule

// File: tb/tb_ci_master.sv
module tb_ci_master;

    localparam int T  = 8;
    localparam int LW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cmdValid = 1'b0;
    logic          cmdReady;
    logic [7:0]    cmdCiN = '0;
    logic [31:0]   cmdValueA = '0;
    logic [31:0]   cmdValueB = '0;
    logic          ciStart;
    logic [7:0]    ciN;
    logic [31:0]   ciValueA;
    logic [31:0]   ciValueB;
    logic          ciStall;
    logic          ciDone = 1'b0;
    logic [31:0]   ciResult = '0;
    logic          rspValid;
    logic          rspReady = 1'b0;
    logic [31:0]   rspResult;
    logic          rspTimeout;
    logic [LW-1:0] rspCycles;
    logic [1:0]    dbgState;

    ci_master #(.TIMEOUT_CYCLES(T), .LAT_WIDTH(LW)) dut (
        .clock(clock), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdCiN(cmdCiN), .cmdValueA(cmdValueA), .cmdValueB(cmdValueB),
        .ciStart(ciStart), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
        .ciStall(ciStall), .ciDone(ciDone), .ciResult(ciResult),
        .rspValid(rspValid), .rspReady(rspReady),
        .rspResult(rspResult), .rspTimeout(rspTimeout), .rspCycles(rspCycles),
        .dbgState(dbgState)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [7:0]    id;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [31:0]   res;
        logic          to;
        logic [LW-1:0] cyc;
    } exp_t;

    typedef struct packed {
        logic [31:0] delay;
        logic [31:0] res;
    } job_t;

    exp_t exp_q[$];
    job_t rq[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: responder answers d cycles after ISSUE (0 = in ISSUE itself).
    // Answers at or before WAIT cycle T are captured; later ones time out.
    function automatic exp_t model(input logic [7:0] id, input logic [31:0] a,
                                   input logic [31:0] b, input int unsigned d,
                                   input logic [31:0] res);
        exp_t e;
        e.id = id;
        e.a  = a;
        e.b  = b;
        if (d <= T) begin
            e.res = res;
            e.to  = 1'b0;
            e.cyc = LW'(d + 1);
        end else begin
            e.res = 32'd0;
            e.to  = 1'b1;
            e.cyc = LW'(T + 1);
        end
        return e;
    endfunction

    // ---------------- responder model ----------------
    job_t        cur;
    int unsigned rcnt = 0;
    bit          ract = 1'b0;

    always @(negedge clock) begin
        ciDone   = 1'b0;
        ciResult = 32'd0;
        if (!reset) begin
            ract = 1'b0;
        end else begin
            if (ciStart) begin
                if (rq.size() != 0) begin
                    cur  = rq.pop_front();
                    rcnt = 0;
                    ract = 1'b1;
                end
            end else if (ract) begin
                rcnt++;
            end
            if (ract && rcnt == cur.delay) begin
                ciDone   = 1'b1;
                ciResult = cur.res;
                ract     = 1'b0;
            end
        end
    end

    // ---------------- rspReady driver ----------------
    bit rand_ready  = 1'b0;
    bit ready_force = 1'b1;

    always @(posedge clock) begin
        #1;
        if (rand_ready) rspReady = ($urandom_range(0, 3) != 0);
        else            rspReady = ready_force;
    end

    // ---------------- monitor ----------------
    exp_t mon_e;
    int   start_cnt = 0;
    int   stall_cnt = 0;

    always @(negedge clock) begin
        if (!reset) begin
            start_cnt = 0;
            stall_cnt = 0;
        end else begin
            if (ciStart) start_cnt++;
            if (ciStall) stall_cnt++;
            if (cmdReady)
                check("idle_operands", 64'(ciValueA | ciValueB | {24'd0, ciN}), 64'd0);
            if (rspValid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_without_cmd", 64'(rspValid), 64'd0);
                end else begin
                    mon_e = exp_q[0];
                    check("rsp_result",  64'(rspResult),  64'(mon_e.res));
                    check("rsp_timeout", 64'(rspTimeout), 64'(mon_e.to));
                    check("rsp_cycles",  64'(rspCycles),  64'(mon_e.cyc));
                    check("held_ciN",    64'(ciN),        64'(mon_e.id));
                    check("held_valueA", 64'(ciValueA),   64'(mon_e.a));
                    check("held_valueB", 64'(ciValueB),   64'(mon_e.b));
                    check("resp_cmd_ready", 64'(cmdReady), 64'd0);
                    if (rspReady) begin
                        check("start_pulses", 64'(start_cnt), 64'd1);
                        check("stall_cycles", 64'(stall_cnt), 64'(mon_e.cyc));
                        void'(exp_q.pop_front());
                        start_cnt = 0;
                        stall_cnt = 0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned d, input logic [31:0] res);
        int n;
        job_t j;
        @(negedge clock);
        cmdValid  = 1'b1;
        cmdCiN    = id;
        cmdValueA = a;
        cmdValueB = b;
        n = 0;
        while (!cmdReady && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!cmdReady) begin
            check("cmd_accept_bound", 64'(cmdReady), 64'd1);
            cmdValid = 1'b0;
            return;
        end
        exp_q.push_back(model(id, a, b, d, res));
        j.delay = d;
        j.res   = res;
        rq.push_back(j);
        @(posedge clock);
        #1;
        cmdValid  = 1'b0;
        cmdCiN    = '0;
        cmdValueA = '0;
        cmdValueB = '0;
        check("start_latency", 64'(ciStart), 64'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        check("drain_bound", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_rsp_valid();
        int n;
        n = 0;
        while (!rspValid && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("rsp_valid_bound", 64'(rspValid), 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2;
        check("rst_cmdReady", 64'(cmdReady), 64'd0);
        check("rst_ciStart",  64'(ciStart),  64'd0);
        check("rst_ciStall",  64'(ciStall),  64'd0);
        check("rst_rspValid", 64'(rspValid), 64'd0);
        check("rst_rsp_data", 64'(rspResult | 32'(rspCycles) | 32'(rspTimeout)), 64'd0);
        check("rst_state",    64'(dbgState), 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check("rel_cmdReady", 64'(cmdReady), 64'd1);

        // single-cycle CI
        send(8'h01, $urandom, $urandom, 0, 32'hCAFE0001);
        wait_idle();

        // profiling id 8, done after 3 cycles
        send(8'h08, 32'd0, 32'h0E1, 3, $urandom);
        wait_idle();

        // unanswered id with a late done landing in RESP
        ready_force = 1'b0;
        send(8'h11, $urandom, $urandom, T + 1, 32'h5A5A5A5A);
        wait_rsp_valid();
        repeat (4) @(negedge clock);
        ready_force = 1'b1;
        wait_idle();

        // backpressure for 5 cycles, then release and issue the next command
        ready_force = 1'b0;
        send(8'h42, $urandom, $urandom, 2, $urandom);
        wait_rsp_valid();
        repeat (5) @(negedge clock);
        ready_force = 1'b1;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check("bp_back_to_idle", 64'({cmdReady, rspValid}), 64'b10);
        send(8'h43, $urandom, $urandom, 1, $urandom);
        wait_idle();

        // done in the timeout cycle: done wins
        send(8'h55, $urandom, $urandom, T, 32'h600DF00D);
        wait_idle();

        // randomized traffic with random response backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), $urandom, $urandom, $urandom_range(0, T + 2), $urandom);
        end
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        wait_idle();

        // reset while in WAIT: command dropped, no response
        send(8'h22, $urandom, $urandom, 6, $urandom);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_ciStart",  64'(ciStart),  64'd0);
        check("mid_rst_ciStall",  64'(ciStall),  64'd0);
        check("mid_rst_rspValid", 64'(rspValid), 64'd0);
        check("mid_rst_cmdReady", 64'(cmdReady), 64'd0);
        check("mid_rst_ciN",      64'(ciN),      64'd0);
        exp_q.delete();
        rq.delete();
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rel_cmdReady", 64'(cmdReady), 64'd1);
        repeat (12) @(negedge clock);

        send(8'h77, $urandom, $urandom, 1, 32'h12345678);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
        $fatal(1);
    end

endmodule
